sipo_frame_ctrl: RTL and testbench
==================================

Name: sipo_frame_ctrl

Overview:
Controller that sequences serial-in/parallel-out capture. It aligns incoming bits to frame boundaries, counts WIDTH accepted bits into an internal shift register, and transfers each completed word to a one-entry output holding buffer. The buffer drains through a valid/ready handshake. The block sits between a serial source and the parallel-word consumer, and replaces free-running SIPO shifting with gated, counted, flow-controlled capture.

Parameters:
WIDTH, 8, bits per parallel word (2..32)
MSB_FIRST, 1, 1 = first received bit lands in par_data[WIDTH-1]; 0 = first bit lands in par_data[0]
CONTINUOUS, 1, 1 = stay in SHIFT after a word completes; 0 = return to IDLE and wait for the next frame_start

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
ser_d  input  1  serial data bit
ser_valid  input  1  ser_d is valid this cycle
frame_start  input  1  single-cycle pulse marking bit 0 of a new word
par_data  output  WIDTH  parallel word from the holding buffer
par_valid  output  1  holding buffer is full
par_ready  input  1  consumer accepts par_data when par_valid & par_ready
overrun  output  1  sticky flag: a completed word was dropped
clr_overrun  input  1  synchronous clear of overrun
busy  output  1  state == SHIFT
bit_cnt  output  $clog2(WIDTH+1)  bits accepted into the current word

Behaviour:
- Reset (async assert, sync release), all outputs 0: state=IDLE; bit_cnt=0; shift reg=0; par_data=0; par_valid=0; overrun=0; busy=0.
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on frame_start. ser_d is ignored in IDLE unless frame_start is high.
  - SHIFT -> IDLE on word completion only when CONTINUOUS=0.
  - frame_start in SHIFT discards the partial word: bit_cnt restarts and there is no overrun.
- Bit acceptance: a bit is accepted on a clk edge when ser_valid=1 and either (state==SHIFT) or (frame_start=1).
  - If frame_start=1, the accepted bit is bit 0 of a new word: bit_cnt becomes 1.
  - Otherwise bit_cnt increments.
  - MSB_FIRST=1: shift left, new bit into LSB. MSB_FIRST=0: shift right, new bit into MSB.
  - After WIDTH bits, the first bit sits at the end named by MSB_FIRST.
- frame_start with ser_valid=0: enters or restarts SHIFT with bit_cnt=0; no bit is taken.
- Word completion: the edge that accepts bit WIDTH.
  - Word goes to the holding buffer on that same edge, so par_valid=1 in the next cycle (1-cycle latency after the last bit).
  - bit_cnt returns to 0 on that edge.
- Holding buffer load rule at completion:
  - Loads if par_valid=0, or if par_valid & par_ready on the same edge (drain and refill simultaneously; par_valid stays 1 with the new data).
  - Otherwise the new word is dropped, par_data is unchanged, and overrun is set.
- Handshake:
  - par_data is stable while par_valid & !par_ready.
  - par_valid falls on the edge where par_ready=1, unless a refill occurs on that edge.
  - par_ready while par_valid=0 has no effect.
- overrun is sticky until clr_overrun. If clr_overrun and a new overrun occur on the same edge, set wins.
- Shifting never stalls on a full buffer; only the completed word is lost.
- Reset asserted mid-word or with par_valid=1: everything clears immediately and the partial word and buffered word are lost.

Test Plan:
- WIDTH=8, MSB_FIRST=1: frame_start with the first bit, then 8 consecutive valid bits 1,0,1,0,0,1,0,1, par_ready=1 -> par_valid=1 for one cycle after the 8th bit with par_data=0xA5; bit_cnt=0 after completion.
- MSB_FIRST=0, same bit stream -> par_data=0xA5 bit-reversed = 0xA5 (palindrome check fails). Therefore use 1,1,0,0,0,0,0,0 -> par_data=0x03 (MSB_FIRST=1 gives 0xC0).
- ser_valid gaps: 8 bits of 0x3C spread with ser_valid low every other cycle -> par_data=0x3C; no bits taken on idle cycles; bit_cnt holds during gaps.
- Mid-word frame_start after 5 bits, then 8 bits of 0x81 -> par_data=0x81; overrun=0; exactly one par_valid.
- par_ready=0, CONTINUOUS=1, two back-to-back words 0x11 then 0x22 -> par_data stays 0x11; overrun=1 after the second completion. clr_overrun -> 0. Raise par_ready on the third word's completion edge -> par_data=third word, par_valid remains 1.
- rst_n low for 1 cycle after 4 bits with par_valid=1 -> all outputs 0 immediately (asynchronously). The next full frame of 0xF0 is received cleanly.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: frame-aligned, counted serial-to-parallel capture with a one-word valid/ready holding buffer
module sipo_frame_ctrl #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit CONTINUOUS = 1'b1,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_d,
  input  logic             ser_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] par_data,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [WIDTH-1:0] sreg, base, nsh;
  logic [CW-1:0] cnt_nx;
  logic take, done, load;
  // a frame_start bit begins a fresh word, so the shift base is cleared
  always_comb begin
    take = ser_valid & ((state == SHIFT) | frame_start);
    base = frame_start ? '0 : sreg;
    nsh = MSB_FIRST ? {base[WIDTH-2:0], ser_d} : {ser_d, base[WIDTH-1:1]};
    cnt_nx = frame_start ? CW'(1) : bit_cnt + CW'(1);
    done = take & (cnt_nx == CW'(WIDTH));
    load = done & (~par_valid | par_ready);
  end
  assign busy = (state == SHIFT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg <= '0;
      bit_cnt <= '0;
      par_data <= '0;
      par_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (frame_start) state <= SHIFT;
      else if (done && !CONTINUOUS) state <= IDLE;
      if (take) begin
        sreg <= nsh;
        bit_cnt <= done ? '0 : cnt_nx;
      end else if (frame_start) begin
        sreg <= '0;
        bit_cnt <= '0;
      end
      if (load) begin
        par_data <= nsh;
        par_valid <= 1'b1;
      end else if (par_ready) par_valid <= 1'b0;
      overrun <= (done & ~load) | (overrun & ~clr_overrun);
    end
  end
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: checks an MSB-first continuous instance and an LSB-first single-word instance against a word-level model
module tb_sipo_frame_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ser_d = 1'b0, ser_valid = 1'b0, frame_start = 1'b0, par_ready = 1'b0, clr_overrun = 1'b0;
  logic [7:0] pd0, pd1;
  logic pv0, pv1, ov0, ov1, bz0, bz1;
  logic [3:0] bc0, bc1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  sipo_frame_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1), .CONTINUOUS(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .ser_d(ser_d), .ser_valid(ser_valid), .frame_start(frame_start),
    .par_data(pd0), .par_valid(pv0), .par_ready(par_ready), .overrun(ov0), .clr_overrun(clr_overrun),
    .busy(bz0), .bit_cnt(bc0));
  sipo_frame_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0), .CONTINUOUS(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .ser_d(ser_d), .ser_valid(ser_valid), .frame_start(frame_start),
    .par_data(pd1), .par_valid(pv1), .par_ready(par_ready), .overrun(ov1), .clr_overrun(clr_overrun),
    .busy(bz1), .bit_cnt(bc1));
  // word-level model: collect bits in arrival order, place them only when the word is complete
  logic m_act[2], m_pv[2], m_ov[2];
  int m_n[2];
  logic [7:0] m_bits[2], m_pd[2];
  function automatic logic [7:0] assemble(input logic [7:0] b, input bit msb);
    logic [7:0] w = '0;
    for (int i = 0; i < 8; i++) if (msb) w[7-i] = b[i]; else w[i] = b[i];
    return w;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_pv[k] = 0; m_ov[k] = 0; m_n[k] = 0; m_bits[k] = 0; m_pd[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit take, done;
        take = ser_valid && (m_act[k] || frame_start);
        done = 0;
        if (frame_start) begin m_act[k] = 1; m_n[k] = 0; m_bits[k] = 0; end
        if (take) begin
          m_bits[k][m_n[k]] = ser_d;
          m_n[k] = m_n[k] + 1;
          done = (m_n[k] == 8);
        end
        if (clr_overrun) m_ov[k] = 0;
        if (done) begin
          m_n[k] = 0;
          if (k == 1) m_act[k] = 0;
          if (!m_pv[k] || par_ready) begin m_pv[k] = 1; m_pd[k] = assemble(m_bits[k], k == 0); end
          else m_ov[k] = 1;
        end else if (m_pv[k] && par_ready) m_pv[k] = 0;
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("u0 par_data", 32'(pd0), 32'(m_pd[0]));
    chk("u0 par_valid", 32'(pv0), 32'(m_pv[0]));
    chk("u0 overrun", 32'(ov0), 32'(m_ov[0]));
    chk("u0 busy", 32'(bz0), 32'(m_act[0]));
    chk("u0 bit_cnt", 32'(bc0), 32'(m_n[0]));
    chk("u1 par_data", 32'(pd1), 32'(m_pd[1]));
    chk("u1 par_valid", 32'(pv1), 32'(m_pv[1]));
    chk("u1 overrun", 32'(ov1), 32'(m_ov[1]));
    chk("u1 busy", 32'(bz1), 32'(m_act[1]));
    chk("u1 bit_cnt", 32'(bc1), 32'(m_n[1]));
  end
  task automatic step(input bit fs, input bit v, input bit d, input bit rdy, input bit clr);
    frame_start = fs; ser_valid = v; ser_d = d; par_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    #1;
  endtask
  // bits go out w[7] first; fs marks the first bit, rdy_last drives par_ready on the completing edge
  task automatic send(input logic [7:0] w, input bit fs, input bit rdy, input bit rdy_last, input bit gap);
    for (int i = 0; i < 8; i++) begin
      step(fs && i == 0, 1, w[7-i], i == 7 ? rdy_last : rdy, 0);
      if (gap && i < 7) step(0, 0, 1, rdy, 0);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset par_data", 32'({pd0, pd1}), 32'h0);
    chk("reset flags", 32'({pv0, ov0, bz0, pv1, ov1, bz1}), 32'h0);
    chk("reset bit_cnt", 32'({bc0, bc1}), 32'h0);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 0);
    send(8'hA5, 1, 1, 1, 0);
    chk("A5 u0 data", 32'(pd0), 32'hA5);
    chk("A5 u1 data", 32'(pd1), 32'hA5);
    chk("A5 valid", 32'({pv0, pv1}), 32'h3);
    chk("A5 bit_cnt", 32'(bc0), 32'h0);
    step(0, 0, 0, 1, 0);
    chk("A5 drained", 32'({pv0, pv1}), 32'h0);
    send(8'hC0, 1, 1, 1, 0);
    chk("C0 u0 data", 32'(pd0), 32'hC0);
    chk("C0 u1 data", 32'(pd1), 32'h03);
    step(0, 0, 0, 1, 0);
    send(8'h3C, 1, 1, 1, 1);
    chk("gap u0 data", 32'(pd0), 32'h3C);
    chk("gap u1 data", 32'(pd1), 32'h3C);
    step(0, 0, 0, 1, 0);
    step(1, 0, 1, 1, 0);
    chk("fs no bit busy", 32'({bz0, bz1}), 32'h3);
    chk("fs no bit cnt", 32'(bc0), 32'h0);
    for (int i = 0; i < 5; i++) step(i == 0, 1, 1, 1, 0);
    chk("partial cnt", 32'(bc0), 32'h5);
    send(8'h81, 1, 1, 1, 0);
    chk("restart u0 data", 32'(pd0), 32'h81);
    chk("restart overrun", 32'({ov0, ov1}), 32'h0);
    step(0, 0, 0, 1, 0);
    send(8'h11, 1, 0, 0, 0);
    send(8'h22, 0, 0, 0, 0);
    chk("ovr u0 data", 32'(pd0), 32'h11);
    chk("ovr u0 flag", 32'(ov0), 32'h1);
    chk("ovr u1 data", 32'(pd1), 32'h88);
    chk("ovr u1 flag", 32'(ov1), 32'h0);
    step(0, 0, 0, 0, 1);
    chk("ovr cleared", 32'(ov0), 32'h0);
    send(8'h33, 1, 0, 1, 0);
    chk("refill u0 data", 32'(pd0), 32'h33);
    chk("refill u1 data", 32'(pd1), 32'hCC);
    chk("refill valid", 32'({pv0, pv1}), 32'h3);
    for (int i = 0; i < 4; i++) step(i == 0, 1, i < 2, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst data", 32'({pd0, pd1}), 32'h0);
    chk("async rst flags", 32'({pv0, ov0, bz0, bc0, pv1, ov1, bz1, bc1}), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'hF0, 1, 1, 1, 0);
    chk("post rst u0 data", 32'(pd0), 32'hF0);
    chk("post rst u1 data", 32'(pd1), 32'h0F);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
